// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Streams bytes into MSB-first 32-bit words, writes them to
//                instruction RAM from index 0, and holds the CPU in reset
//                until the final word has been committed.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_RUN   = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(MEM_DEPTH);

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_byte_cnt;
    logic [31:0]         r_word;
    logic [ADDR_W:0]     r_words_loaded;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;

    logic                w_full;
    logic                w_xfer;
    logic                w_clear;
    logic [31:0]         w_shifted;
    logic [4:0]          w_pad;

    assign w_full    = (r_words_loaded == c_depth);
    assign w_shifted = {r_word[23:0], in_data};
    // A word closed early on byte k needs (3-k) zero bytes below it; 3-k == ~k.
    assign w_pad     = {~r_byte_cnt, 3'b000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        cpu_reset = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        w_clear   = 1'b0;
        w_xfer    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clear = 1'b1;
                    w_next  = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = !w_full;
                w_xfer   = in_valid && !w_full;
                if (w_xfer && in_last) begin
                    w_next = S_FLUSH;
                end else if (in_valid && w_full) begin
                    w_next = S_ERROR;
                end
            end
            S_FLUSH: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
                if (start) begin
                    w_clear = 1'b1;
                    w_next  = S_LOAD;
                end
            end
            S_ERROR: begin
                err = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte_cnt     <= 2'd0;
            r_word         <= 32'd0;
            r_words_loaded <= '0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= 32'd0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_clear) begin
                r_byte_cnt     <= 2'd0;
                r_word         <= 32'd0;
                r_words_loaded <= '0;
            end else if (w_xfer) begin
                if (r_byte_cnt == 2'd3 || in_last) begin
                    r_mem_we       <= 1'b1;
                    r_mem_addr     <= r_words_loaded[ADDR_W-1:0];
                    r_mem_wdata    <= w_shifted << w_pad;
                    r_words_loaded <= r_words_loaded + 1'b1;
                    r_byte_cnt     <= 2'd0;
                    r_word         <= 32'd0;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    r_word     <= w_shifted;
                end
            end
        end
    end

    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Scoreboard bench for prog_loader; expected RAM writes are
//                queued by the stimulus and checked by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int DEPTH = 24;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          in_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    int            n_checks = 0;
    int            n_errors = 0;
    int            exp_addr[$];
    logic [31:0]   exp_data[$];

    prog_loader #(.MEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expectation queue
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_data.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                chk("write_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
                chk("write_data", mem_wdata, exp_data.pop_front());
            end
        end
    end

    task automatic push(input int a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic send(input logic [7:0] d, input logic last, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got in_ready %b expected 1 within 50 cycles", in_ready);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        send(w[31:24], 1'b0, 0);
        send(w[23:16], 1'b0, 0);
        send(w[15:8],  1'b0, 0);
        send(w[7:0],   last, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the falling edge inside the FLUSH cycle
    task automatic finish_load(input int n);
        chk("flush_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("flush_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("run_done", 32'(done), 32'd1);
        chk("run_in_ready", 32'(in_ready), 32'd0);
        chk("run_words_loaded", 32'(words_loaded), 32'(n));
        @(negedge clk);
        chk("queue_drained", 32'(exp_data.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  stall_bytes [8];
        int          stall_gaps  [8];
        stall_bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        stall_gaps  = '{2, 0, 3, 1, 0, 4, 1, 2};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        // Program load: 22 words, in_last on byte 88
        pulse_start();
        chk("start_in_ready", 32'(in_ready), 32'd1);
        chk("start_cpu_reset", 32'(cpu_reset), 32'd1);
        for (int i = 0; i < 22; i++) begin
            w = {8'(i), 8'(8'h10 + i), ~8'(i), 8'(3 * i)};
            push(i, w);
            send_word(w, i == 21);
        end
        finish_load(22);

        // Reload from RUN
        pulse_start();
        chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_words_loaded", 32'(words_loaded), 32'd0);
        push(0, 32'hDEADBEEF);
        send_word(32'hDEADBEEF, 1'b1);
        finish_load(1);

        // Partial final word (two bytes into the second word)
        pulse_start();
        push(0, 32'h11223344);
        push(1, 32'h55660000);
        send(8'h11, 1'b0, 0); send(8'h22, 1'b0, 0); send(8'h33, 1'b0, 0);
        send(8'h44, 1'b0, 0); send(8'h55, 1'b0, 0); send(8'h66, 1'b1, 0);
        finish_load(2);

        // Single-byte program
        pulse_start();
        push(0, 32'h5A000000);
        send(8'h5A, 1'b1, 0);
        finish_load(1);

        // Three-byte program
        pulse_start();
        push(0, 32'h01020300);
        send(8'h01, 1'b0, 0); send(8'h02, 1'b0, 0); send(8'h03, 1'b1, 0);
        finish_load(1);

        // Valid gaps between bytes
        pulse_start();
        push(0, 32'hA0A1A2A3);
        push(1, 32'hA4A5A6A7);
        for (int i = 0; i < 8; i++) send(stall_bytes[i], i == 7, stall_gaps[i]);
        finish_load(2);

        // Reset in the middle of the second word
        pulse_start();
        push(0, 32'h10203040);
        send(8'h10, 1'b0, 0); send(8'h20, 1'b0, 0); send(8'h30, 1'b0, 0);
        send(8'h40, 1'b0, 0); send(8'h50, 1'b0, 0); send(8'h60, 1'b0, 0);
        reset = 1'b1;
        #1;
        chk_reset_vals("midreset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd0);
        chk("post_reset_queue", 32'(exp_data.size()), 32'd0);
        pulse_start();
        push(0, 32'h77665544);
        send_word(32'h77665544, 1'b1);
        finish_load(1);

        // Overflow: fill all DEPTH words, then present one more byte
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            w = 32'hC0000000 | 32'(i);
            push(i, w);
            send_word(w, 1'b0);
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_words_loaded", 32'(words_loaded), 32'(DEPTH));
        chk("full_err", 32'(err), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_in_ready", 32'(in_ready), 32'd0);
        chk("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("ovf_done", 32'(done), 32'd0);
        chk("ovf_words_loaded", 32'(words_loaded), 32'(DEPTH));
        pulse_start();
        chk("ovf_start_ignored", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        chk("ovf_err_sticky", 32'(err), 32'd1);
        chk("ovf_queue_drained", 32'(exp_data.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
